axil_wr_rd_checker: RTL

AXIL_WR_RD_CHECKER -- requirements
Module: axil_wr_rd_checker

---
 rtl/axil_wr_rd_checker.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axil_wr_rd_checker.sv
// rtl/axil_wr_rd_checker.sv - AXI4-Lite master that writes a data pattern, reads it back and counts mismatches
module axil_wr_rd_checker #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                   NUM_VECTORS        = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STRIDE        = C_M_AXI_ADDR_WIDTH'(4),
  parameter logic [31:0]                   SEED               = 32'h0101FFFF,
  parameter logic [31:0]                   DATA_INCR          = 32'h01010101,
  parameter bit                            STOP_ON_ERR        = 1'b0,
  parameter int unsigned                   TIMEOUT_CYCLES     = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [8:0]                      err_count,
  output logic [7:0]                      first_err_idx,
  output logic                            timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_VECTORS - 1);
  localparam int unsigned   REP      = C_M_AXI_DATA_WIDTH / 32;

  logic [2:0]                    state;
  logic [7:0]                    idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]                   cur_pat;
  logic [CW-1:0]                 wait_cnt;
  logic                          vec_fail;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    rresp_q;
  logic                          in_wait;
  logic                          stage_ok;
  logic                          to_event;
  logic                          fail_now;
  logic                          err_event;

  // Address and pattern advance incrementally, so wrap-around is plain modular addition
  assign M_AXI_AWADDR = cur_addr;
  assign M_AXI_ARADDR = cur_addr;
  assign M_AXI_WDATA  = {REP{cur_pat}};
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_comb begin
    in_wait  = 1'b0;
    stage_ok = 1'b0;
    case (state)
      S_WR: begin
        in_wait  = 1'b1;
        stage_ok = (!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY);
      end
      S_WRESP: begin
        in_wait  = 1'b1;
        stage_ok = M_AXI_BVALID;
      end
      S_RD: begin
        in_wait  = 1'b1;
        stage_ok = M_AXI_ARREADY;
      end
      S_RDATA: begin
        in_wait  = 1'b1;
        stage_ok = M_AXI_RVALID;
      end
      default: ;
    endcase
    to_event  = in_wait && !stage_ok && (wait_cnt == TO_LAST);
    fail_now  = vec_fail || (rresp_q != 2'b00) || (rdata_q != M_AXI_WDATA);
    err_event = to_event || ((state == S_CHECK) && fail_now);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= S_IDLE;
      idx           <= '0;
      cur_addr      <= '0;
      cur_pat       <= '0;
      wait_cnt      <= '0;
      vec_fail      <= 1'b0;
      rdata_q       <= '0;
      rresp_q       <= 2'b00;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      wait_cnt <= in_wait ? wait_cnt + CW'(1) : '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_WR;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            idx           <= '0;
            cur_addr      <= BASE_ADDR;
            cur_pat       <= SEED;
            vec_fail      <= 1'b0;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
          end
        end
        S_WR: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if (stage_ok) begin
            state        <= S_WRESP;
            wait_cnt     <= '0;
            M_AXI_BREADY <= 1'b1;
          end
        end
        S_WRESP: begin
          if (stage_ok) begin
            vec_fail      <= vec_fail || (M_AXI_BRESP != 2'b00);
            state         <= S_RD;
            wait_cnt      <= '0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b1;
          end
        end
        S_RD: begin
          if (stage_ok) begin
            state         <= S_RDATA;
            wait_cnt      <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
          end
        end
        S_RDATA: begin
          if (stage_ok) begin
            state        <= S_CHECK;
            rdata_q      <= M_AXI_RDATA;
            rresp_q      <= M_AXI_RRESP;
            M_AXI_RREADY <= 1'b0;
          end
        end
        S_CHECK: begin
          vec_fail <= fail_now;
          state    <= S_NEXT;
        end
        S_NEXT: begin
          if ((idx == LAST_IDX) || (STOP_ON_ERR && vec_fail)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 9'd0) && !timeout;
          end else begin
            state         <= S_WR;
            idx           <= idx + 8'd1;
            cur_addr      <= cur_addr + ADDR_STRIDE;
            cur_pat       <= cur_pat + DATA_INCR;
            vec_fail      <= 1'b0;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // A stalled channel abandons the vector: drop every handshake and skip the compare
      if (to_event) begin
        timeout       <= 1'b1;
        vec_fail      <= 1'b1;
        state         <= S_NEXT;
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_count     <= '0;
      first_err_idx <= '0;
    end else if ((state == S_IDLE) && start) begin
      err_count     <= '0;
      first_err_idx <= '0;
    end else if (err_event) begin
      if (err_count != 9'd511) err_count <= err_count + 9'd1;
      if (err_count == 9'd0)   first_err_idx <= idx;
    end
  end

endmodule
